// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush generation for a 5-stage pipeline.
// Handles load-use hazards, taken branches/jumps resolved in EX, external
// (trap) flushes, and multi-cycle EX ops (MUL/DIV) via a two-state FSM with
// a latency down-counter.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating perf counters
// perf_stall_cnt / perf_flush_cnt.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_md,
    input  logic                  ex_br_taken,
    input  logic                  ext_flush,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  id_ex_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    // Parameter sanity: a multi-cycle op must occupy EX for at least 2 cycles.
    if (MD_LAT < 2) begin : g_bad_md_lat
        $error("hazard_ctrl_unit: MD_LAT must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl_unit: CNT_W must be >= 1");
    end

    localparam int CNT_BITS = $clog2(MD_LAT);
    // Entry cycle counts as one stall cycle, so the counter starts at MD_LAT-2.
    localparam logic [CNT_BITS-1:0] MD_LOAD = CNT_BITS'(MD_LAT - 2);

    typedef enum logic {S_RUN, S_MD} state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic                load_use;
    logic                md_stall;

    // Hazard detection terms shared by output decode.
    always_comb begin
        load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) |
                    (id_use_rs2 & (id_rs2 == ex_rd)));
        md_stall = ((state == S_RUN) & ex_is_md) |
                   ((state == S_MD) & (cnt != '0));
    end

    // Output decode: ext_flush > md stall > branch flush > load-use stall.
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        if (!rst) begin
            md_busy = (state == S_MD);
            if (ext_flush) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (md_stall) begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (state == S_RUN) begin
                if (ex_br_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    // Multi-cycle op FSM and latency counter; ext_flush aborts an op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else if (ext_flush) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (ex_is_md) begin
                        state <= S_MD;
                        cnt   <= MD_LOAD;
                    end
                end
                S_MD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Saturating perf counters: stall cycles (pc_hold) and cycles with any flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= sat_inc(perf_stall_cnt, pc_hold);
            perf_flush_cnt <= sat_inc(perf_flush_cnt,
                                      if_id_flush | id_ex_flush | ex_mem_flush);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

    localparam int REG_ADDR_W = 5;
    localparam int MD_LAT     = 4;
    localparam int CNT_W      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                  id_use_rs1, id_use_rs2;
    logic                  ex_mem_read, ex_reg_write, ex_is_md, ex_br_taken, ext_flush;
    logic                  pc_hold, if_id_hold, id_ex_hold;
    logic                  if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]      perf_stall_cnt, perf_flush_cnt;
    logic [CNT_W-1:0]      m_stall_cnt, m_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index of the current multi-cycle op cycle (0 = none, 1 = entry).
    int md_cyc = 0;

    // Expected outputs for the current cycle.
    logic e_pc_hold, e_if_id_hold, e_id_ex_hold;
    logic e_if_id_flush, e_id_ex_flush, e_ex_mem_flush, e_md_busy;
    int   cur_cyc;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_ADDR_W(REG_ADDR_W),
        .MD_LAT    (MD_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .ex_is_md    (ex_is_md),
        .ex_br_taken (ex_br_taken),
        .ext_flush   (ext_flush),
        .pc_hold     (pc_hold),
        .if_id_hold  (if_id_hold),
        .id_ex_hold  (id_ex_hold),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .md_busy     (md_busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_is_md = 0;
        ex_br_taken = 0; ext_flush = 0;
    endtask

    // Expected outputs from the rules: priority ext_flush > md > branch > load-use.
    task automatic model_eval();
        logic lu;
        lu = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        cur_cyc = (!rst && !ext_flush && md_cyc == 0 && ex_is_md) ? 1 : md_cyc;
        {e_pc_hold, e_if_id_hold, e_id_ex_hold} = '0;
        {e_if_id_flush, e_id_ex_flush, e_ex_mem_flush, e_md_busy} = '0;
        if (!rst) begin
            e_md_busy = (md_cyc >= 2);
            if (ext_flush) begin
                {e_if_id_flush, e_id_ex_flush, e_ex_mem_flush} = 3'b111;
            end else if (cur_cyc >= 1 && cur_cyc <= MD_LAT - 1) begin
                {e_pc_hold, e_if_id_hold, e_id_ex_hold, e_ex_mem_flush} = 4'b1111;
            end else if (cur_cyc == 0) begin
                if (ex_br_taken) begin
                    {e_if_id_flush, e_id_ex_flush} = 2'b11;
                end else if (lu) begin
                    {e_pc_hold, e_if_id_hold, e_id_ex_flush} = 3'b111;
                end
            end
        end
    endtask

    task automatic model_next();
        if (rst || ext_flush || cur_cyc == MD_LAT) md_cyc = 0;
        else if (cur_cyc > 0)                        md_cyc = cur_cyc + 1;
        else                                         md_cyc = 0;
`ifdef HAZ_PERF_CNT_EN
        if (rst) begin
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            if (e_pc_hold && m_stall_cnt != '1) m_stall_cnt = m_stall_cnt + 1;
            if ((e_if_id_flush || e_id_ex_flush || e_ex_mem_flush) && m_flush_cnt != '1)
                m_flush_cnt = m_flush_cnt + 1;
        end
`endif
    endtask

    // Inputs are set shortly after a posedge; outputs are sampled mid-cycle.
    task automatic step();
        model_eval();
        #2;
        chk("pc_hold",      pc_hold,      e_pc_hold);
        chk("if_id_hold",   if_id_hold,   e_if_id_hold);
        chk("id_ex_hold",   id_ex_hold,   e_id_ex_hold);
        chk("if_id_flush",  if_id_flush,  e_if_id_flush);
        chk("id_ex_flush",  id_ex_flush,  e_id_ex_flush);
        chk("ex_mem_flush", ex_mem_flush, e_ex_mem_flush);
        chk("md_busy",      md_busy,      e_md_busy);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
        chk("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
        @(posedge clk);
        model_next();
        #1;
    endtask

    initial begin
`ifdef HAZ_PERF_CNT_EN
        m_stall_cnt = '0;
        m_flush_cnt = '0;
`endif
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        // Reset: every output forced low even with hazards presented.
        ex_is_md = 1; ext_flush = 1;
        step();
        chk("rst_md_busy", md_busy, 1'b0);
        clear_inputs();
        step();
        rst = 0;

        // Load x5 in EX, ID reads rs1=x5: one stall cycle, then quiet.
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        step();
        clear_inputs();
        step();

        // Load to x0 read by ID: no stall.
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        step();
        // rs2 matches but is not used: no stall.
        clear_inputs();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 0;
        step();

        // Multi-cycle op held high: stall MD_LAT-1 cycles, release on the last.
        clear_inputs();
        ex_is_md = 1;
        repeat (MD_LAT) step();
        clear_inputs();
        step();

        // Branch and load-use together: branch flush wins, no holds.
        ex_br_taken = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7;
        id_rs1 = 7; id_use_rs1 = 1;
        step();
        chk("br_over_lu_hold", pc_hold, 1'b0);
        clear_inputs();

        // ext_flush on the second S_MD cycle aborts the op.
        ex_is_md = 1;
        step();
        step();
        ext_flush = 1;
        step();
        clear_inputs();
        step();
        chk("md_abort_busy", md_busy, 1'b0);

        // Reset mid-op: outputs low during reset, no residual stall after.
        ex_is_md = 1;
        step();
        ex_is_md = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        step();

        // Random stimulus with small register indices to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            ext_flush    = ($urandom_range(0, 99) < 5);
            ex_is_md     = ($urandom_range(0, 99) < 12);
            ex_br_taken  = ($urandom_range(0, 99) < 15);
            ex_mem_read  = ($urandom_range(0, 99) < 50);
            ex_reg_write = ($urandom_range(0, 99) < 80);
            ex_rd        = REG_ADDR_W'($urandom_range(0, 3));
            id_rs1       = REG_ADDR_W'($urandom_range(0, 3));
            id_rs2       = REG_ADDR_W'($urandom_range(0, 3));
            id_use_rs1   = $urandom_range(0, 1);
            id_use_rs2   = $urandom_range(0, 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
